// File: rtl/decode_pkg.sv
// Shared constants, decoded-bundle type and immediate generator for the RV32I decode queue.
// Optional M-extension decode is enabled by defining RV_M_EXT_EN.
package decode_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ALU_W   = 4;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned IMMT_W  = 3;
   localparam int unsigned CLASS_W = 12;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [IMMT_W-1:0] IMM_I    = 3'b000;
   localparam logic [IMMT_W-1:0] IMM_S    = 3'b001;
   localparam logic [IMMT_W-1:0] IMM_B    = 3'b010;
   localparam logic [IMMT_W-1:0] IMM_U    = 3'b011;
   localparam logic [IMMT_W-1:0] IMM_J    = 3'b100;
   localparam logic [IMMT_W-1:0] IMM_C    = 3'b101;
   localparam logic [IMMT_W-1:0] IMM_SH   = 3'b110;
   localparam logic [IMMT_W-1:0] IMM_NONE = 3'b111;

   localparam logic [SEL_W-1:0] SEL_REG  = 2'b00;
   localparam logic [SEL_W-1:0] SEL_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SEL_PC   = 2'b10;
   localparam logic [SEL_W-1:0] SEL_ZERO = 2'b11;

   localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1101;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'b0111;

   localparam int unsigned CLS_OP       = 0;
   localparam int unsigned CLS_LUI      = 1;
   localparam int unsigned CLS_AUIPC    = 2;
   localparam int unsigned CLS_JAL      = 3;
   localparam int unsigned CLS_JALR     = 4;
   localparam int unsigned CLS_BRANCH   = 5;
   localparam int unsigned CLS_LOAD     = 6;
   localparam int unsigned CLS_STORE    = 7;
   localparam int unsigned CLS_MISC_MEM = 8;
   localparam int unsigned CLS_SYSTEM   = 9;
   localparam int unsigned CLS_MULDIV   = 10;
   localparam int unsigned CLS_ILLEGAL  = 11;

   typedef struct packed {
      logic [2:0]         funct3;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      logic [XLEN-1:0]    imm;
      logic [SEL_W-1:0]   sel_a;
      logic [SEL_W-1:0]   sel_b;
      logic [ALU_W-1:0]   alu_op;
      logic [11:0]        csr_addr;
      logic [CLASS_W-1:0] cls;
   } dec_bundle_t;

   function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] inst, input logic [IMMT_W-1:0] typ);
      logic [XLEN-1:0] imm;
      imm = '0;
      case (typ)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'h000};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_C:   imm = {27'd0, inst[19:15]};
         IMM_SH:  imm = {27'd0, inst[24:20]};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I instruction-to-bundle decoder with strict legality checking.
// Defining RV_M_EXT_EN makes OP funct7=0000001 decode as muldiv instead of illegal.
module decode_logic
   import decode_pkg::*;
(
   input  logic [31:0]  inst_i,
   output dec_bundle_t  bundle_o
);

   logic [2:0]        w_funct3;
   logic [6:0]        w_funct7;
   logic [IMMT_W-1:0] w_imm_type;
   logic              w_illegal;
   logic              w_shift;

   assign w_funct3 = inst_i[14:12];
   assign w_funct7 = inst_i[31:25];
   assign w_shift  = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

   always_comb begin
      bundle_o          = '0;
      w_imm_type        = IMM_NONE;
      w_illegal         = 1'b0;
      bundle_o.funct3   = w_funct3;
      bundle_o.rs1      = inst_i[19:15];
      bundle_o.rs2      = inst_i[24:20];
      bundle_o.rd       = inst_i[11:7];
      bundle_o.csr_addr = inst_i[31:20];
      bundle_o.sel_a    = SEL_REG;
      bundle_o.sel_b    = SEL_REG;
      bundle_o.alu_op   = ALU_ADD;

      case (inst_i[6:0])
         OPC_LUI: begin
            bundle_o.cls[CLS_LUI] = 1'b1;
            w_imm_type     = IMM_U;
            bundle_o.sel_a = SEL_IMM;
            bundle_o.sel_b = SEL_ZERO;
         end
         OPC_AUIPC, OPC_JAL: begin
            bundle_o.cls[CLS_AUIPC] = (inst_i[6:0] == OPC_AUIPC);
            bundle_o.cls[CLS_JAL]   = (inst_i[6:0] == OPC_JAL);
            w_imm_type     = (inst_i[6:0] == OPC_JAL) ? IMM_J : IMM_U;
            bundle_o.sel_a = SEL_PC;
            bundle_o.sel_b = SEL_IMM;
         end
         OPC_JALR: begin
            bundle_o.cls[CLS_JALR] = 1'b1;
            w_illegal      = (w_funct3 != 3'b000);
            w_imm_type     = IMM_I;
            bundle_o.sel_b = SEL_IMM;
         end
         OPC_BRANCH: begin
            bundle_o.cls[CLS_BRANCH] = 1'b1;
            w_illegal  = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            w_imm_type = IMM_B;
         end
         OPC_LOAD: begin
            bundle_o.cls[CLS_LOAD] = 1'b1;
            w_illegal      = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
            w_imm_type     = IMM_I;
            bundle_o.sel_b = SEL_IMM;
         end
         OPC_STORE: begin
            bundle_o.cls[CLS_STORE] = 1'b1;
            w_illegal      = (w_funct3 >= 3'b011);
            w_imm_type     = IMM_S;
            bundle_o.sel_b = SEL_IMM;
         end
         OPC_MISC_MEM: begin
            bundle_o.cls[CLS_MISC_MEM] = 1'b1;
            w_imm_type = IMM_I;
         end
         OPC_SYSTEM: begin
            bundle_o.cls[CLS_SYSTEM] = 1'b1;
            w_imm_type     = w_funct3[2] ? IMM_C : IMM_I;
            bundle_o.sel_a = w_funct3[2] ? SEL_IMM : SEL_REG;
            bundle_o.sel_b = SEL_IMM;
         end
         OPC_OP_IMM: begin
            bundle_o.cls[CLS_OP] = 1'b1;
            bundle_o.sel_b       = SEL_IMM;
            if (w_shift) begin
               w_imm_type      = IMM_SH;
               bundle_o.alu_op = {inst_i[30], w_funct3};
               w_illegal       = !((w_funct7 == 7'b0000000) ||
                                   ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b101)));
            end else begin
               w_imm_type      = IMM_I;
               bundle_o.alu_op = {1'b0, w_funct3};
            end
         end
         OPC_OP: begin
            bundle_o.cls[CLS_OP] = 1'b1;
            bundle_o.alu_op      = {inst_i[30], w_funct3};
            if (w_funct7 == 7'b0000000) begin
               w_illegal = 1'b0;
            end else if (w_funct7 == 7'b0100000) begin
               w_illegal = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
`ifdef RV_M_EXT_EN
            end else if (w_funct7 == 7'b0000001) begin
               bundle_o.cls[CLS_OP]     = 1'b0;
               bundle_o.cls[CLS_MULDIV] = 1'b1;
               bundle_o.alu_op          = {1'b0, w_funct3};
`endif
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase

      if (inst_i[1:0] != 2'b11) w_illegal = 1'b1;
      // Illegal encodings carry only the illegal class bit.
      if (w_illegal) begin
         bundle_o.cls              = '0;
         bundle_o.cls[CLS_ILLEGAL] = 1'b1;
      end
      bundle_o.imm = gen_imm(inst_i, w_imm_type);
   end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes fetched instructions at push and buffers DEPTH decoded bundles for execute.
// Build option RV_M_EXT_EN (in decode_logic) enables M-extension decode.
module decode_queue
   import decode_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned PC_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                inst_valid_i,
   output logic                inst_ready_o,
   input  logic [31:0]         inst_i,
   input  logic [PC_WIDTH-1:0] pc_i,
   output logic                dec_valid_o,
   input  logic                dec_ready_i,
   output logic [PC_WIDTH-1:0] pc_o,
   output logic [2:0]          funct3_o,
   output logic [4:0]          rs1_o,
   output logic [4:0]          rs2_o,
   output logic [4:0]          rd_o,
   output logic [31:0]         imm_o,
   output logic [1:0]          sel_dat_a_o,
   output logic [1:0]          sel_dat_b_o,
   output logic [3:0]          alu_op_o,
   output logic [11:0]         csr_addr_o,
   output logic [11:0]         class_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0]    r_count;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   dec_bundle_t         r_mem [DEPTH];
   logic [PC_WIDTH-1:0] r_pc  [DEPTH];

   dec_bundle_t         w_dec;
   dec_bundle_t         w_head;
   logic                w_valid;
   logic                w_push;
   logic                w_pop;

   decode_logic u_decode_logic (
      .inst_i   (inst_i),
      .bundle_o (w_dec)
   );

   assign w_valid      = (r_count != '0);
   assign inst_ready_o = (r_count != CNT_W'(DEPTH));
   assign w_push       = inst_valid_i && inst_ready_o && !flush_i;
   assign w_pop        = w_valid && dec_ready_i && !flush_i;

   // Pointer/count control; flush empties the queue and drops same-cycle input.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush_i) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_dec;
         r_pc[r_wr_ptr]  <= pc_i;
      end
   end

   // Head entry is masked to zero whenever the queue is empty.
   assign w_head      = w_valid ? r_mem[r_rd_ptr] : '0;
   assign pc_o        = w_valid ? r_pc[r_rd_ptr]  : '0;
   assign dec_valid_o = w_valid;
   assign funct3_o    = w_head.funct3;
   assign rs1_o       = w_head.rs1;
   assign rs2_o       = w_head.rs2;
   assign rd_o        = w_head.rd;
   assign imm_o       = w_head.imm;
   assign sel_dat_a_o = w_head.sel_a;
   assign sel_dat_b_o = w_head.sel_b;
   assign alu_op_o    = w_head.alu_op;
   assign csr_addr_o  = w_head.csr_addr;
   assign class_o     = w_head.cls;

endmodule
